ks_multiword_adder: RTL and testbench

Sequencer that performs a WORDS×N-bit two's-complement add or subtract by running one N-bit `KoggeStoneAdder` for WORDS consecutive cycles, least-significant word first. The carry is registered between words. It gives the datapath wide-precision arithmetic without building a WORDS×N-bit prefix tree. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/ks_multiword_adder_pkg.sv | 10 +
 rtl/ks_multiword_adder_if.sv | 30 +++
 rtl/ks_multiword_adder_kogge.sv | 36 +++
 rtl/ks_multiword_adder.sv | 95 +++++++++
 tb/tb_ks_multiword_adder.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/ks_multiword_adder_pkg.sv
// ks_multiword_pkg: shared state encoding and sizing helper for the multiword adder
package ks_multiword_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_w(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/ks_multiword_adder_if.sv
// ks_multiword_adder_if: operand/result handshake bundle for the multiword adder
interface ks_multiword_adder_if #(
    parameter int N     = 64,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         inValid;
    logic         inReady;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] S;
    logic         Cout;
    logic         overflowFlag;

    modport master (
        output inValid, A, B, Cin, Sub, outReady,
        input  inReady, outValid, S, Cout, overflowFlag
    );

    modport slave (
        input  inValid, A, B, Cin, Sub, outReady,
        output inReady, outValid, S, Cout, overflowFlag
    );

endinterface

// File: rtl/ks_multiword_adder_kogge.sv
// KoggeStoneAdder: N-bit parallel-prefix adder with carry-in, carry-out and signed overflow
module KoggeStoneAdder #(
    parameter int N = 64
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         overflowFlag
);
    localparam int L = $clog2(N);

    logic [N-1:0] x;
    logic [N-1:0] g;
    logic [N-1:0] p;

    // prefix tree evaluated in place; descending index keeps each level reading the previous level
    always_comb begin
        x = A ^ B;
        g = A & B;
        p = x;
        g[0] = g[0] | (p[0] & Cin);
        for (int l = 0; l < L; l++) begin
            for (int i = N - 1; i >= (1 << l); i--) begin
                g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                p[i] = p[i] & p[i - (1 << l)];
            end
        end
    end

    assign S            = x ^ {g[N-2:0], Cin};
    assign Cout         = g[N-1];
    assign overflowFlag = g[N-1] ^ g[N-2];

endmodule

// File: rtl/ks_multiword_adder.sv
// ks_multiword_adder: WORDS x N-bit add/subtract by reusing one N-bit Kogge-Stone slice over WORDS cycles
module ks_multiword_adder
    import ks_multiword_pkg::*;
#(
    parameter int N     = 64,
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    ks_multiword_adder_if.slave bus
);
    localparam int W  = N * WORDS;
    localparam int CW = cnt_w(WORDS);

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   a_sr;
    logic [W-1:0]   b_sr;
    logic [W-N-1:0] r_sr;
    logic [W-1:0]   res_n;
    logic [W-1:0]   s_q;
    logic           carry;
    logic           cout_q;
    logic           ovf_q;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   sum;
    logic           co;
    logic           ov;
    logic           accept;
    logic           last;

    KoggeStoneAdder #(.N(N)) u_ks (
        .A            (a_sr[N-1:0]),
        .B            (b_sr[N-1:0]),
        .Cin          (carry),
        .S            (sum),
        .Cout         (co),
        .overflowFlag (ov)
    );

    assign accept = (state == IDLE) && bus.inValid;
    assign last   = cnt == CW'(WORDS - 1);
    assign res_n  = {sum, r_sr};

    // next state: accept starts a run, last word finishes it, consumer handshake releases it
    always_comb begin
        state_n = (state == IDLE && bus.inValid)  ? RUN  :
                  (state == RUN  && last)         ? DONE :
                  (state == DONE && bus.outReady) ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // operand/result shift registers, inter-word carry and captured outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.A;
            b_sr  <= bus.Sub ? ~bus.B : bus.B;
            carry <= bus.Sub | bus.Cin;
            cnt   <= '0;
            r_sr  <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> N;
            b_sr  <= b_sr >> N;
            r_sr  <= res_n[W-1:N];
            carry <= co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                s_q    <= res_n;
                cout_q <= co;
                ovf_q  <= ov;
            end
        end
    end

    assign bus.inReady      = state == IDLE;
    assign bus.outValid     = state == DONE;
    assign bus.S            = s_q;
    assign bus.Cout         = cout_q;
    assign bus.overflowFlag = ovf_q;

endmodule

// File: tb/tb_ks_multiword_adder.sv
// tb_ks_multiword_adder: directed vectors plus a scoreboarded 33-bit arithmetic model for the multiword adder
module tb_ks_multiword_adder;
    localparam int N     = 8;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [33:0] exp_q[$];

    ks_multiword_adder_if #(.N(N), .WORDS(WORDS)) bus ();

    ks_multiword_adder #(.N(N), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // plain W-bit arithmetic: {overflow, carry, sum}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bx;
        logic [32:0] full;
        logic        ovf;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + 33'(sub | cin);
        ovf  = (a[31] == bx[31]) && (full[31] != a[31]);
        return {ovf, full};
    endfunction

    // scoreboard: push on accept, compare while outValid, pop on consumer handshake
    always @(negedge clk) begin
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.outValid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_outValid", 64'(bus.outValid), 64'd0);
                end else begin
                    chk("sb_S", 64'(bus.S), 64'(exp_q[0][31:0]));
                    chk("sb_Cout", 64'(bus.Cout), 64'(exp_q[0][32]));
                    chk("sb_ovf", 64'(bus.overflowFlag), 64'(exp_q[0][33]));
                    if (bus.outReady) void'(exp_q.pop_front());
                end
            end
            if (bus.inValid && bus.inReady)
                exp_q.push_back(model(bus.A, bus.B, bus.Cin, bus.Sub));
        end
    end

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] es,
                          input logic ec, input logic ev, input int hold);
        int lat;
        logic [31:0] s0;
        chk({name, "_inReady"}, 64'(bus.inReady), 64'd1);
        bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub;
        bus.inValid = 1'b1;
        bus.outReady = (hold == 0);
        @(negedge clk);
        bus.inValid = 1'b0;
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Sub = 1'b0;
        lat = 1;
        while (!bus.outValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd5);
        chk({name, "_S"}, 64'(bus.S), 64'(es));
        chk({name, "_Cout"}, 64'(bus.Cout), 64'(ec));
        chk({name, "_ovf"}, 64'(bus.overflowFlag), 64'(ev));
        s0 = bus.S;
        for (int k = 0; k < hold; k++) begin
            bus.inValid = (k == 1);
            bus.A = 32'h11111111; bus.B = 32'h22222222;
            @(negedge clk);
            chk({name, "_hold_outValid"}, 64'(bus.outValid), 64'd1);
            chk({name, "_hold_inReady"}, 64'(bus.inReady), 64'd0);
            chk({name, "_hold_S"}, 64'(bus.S), 64'(s0));
            chk({name, "_hold_Cout"}, 64'(bus.Cout), 64'(ec));
            chk({name, "_hold_ovf"}, 64'(bus.overflowFlag), 64'(ev));
        end
        bus.inValid = 1'b0;
        bus.A = '0; bus.B = '0;
        bus.outReady = 1'b1;
        @(negedge clk);
        chk({name, "_after_outValid"}, 64'(bus.outValid), 64'd0);
        chk({name, "_after_inReady"}, 64'(bus.inReady), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [33:0] m;
        bit seen;
        bus.inValid = 1'b0; bus.outReady = 1'b1;
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_inReady", 64'(bus.inReady), 64'd1);
        chk("rst_outValid", 64'(bus.outValid), 64'd0);
        chk("rst_S", 64'(bus.S), 64'd0);
        chk("rst_Cout", 64'(bus.Cout), 64'd0);
        chk("rst_ovf", 64'(bus.overflowFlag), 64'd0);

        run_op("zero", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        run_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
        run_op("sovf", 32'h4FFFFFFF, 32'h4FFFFFFF, 1'b1, 1'b0, 32'h9FFFFFFF, 1'b0, 1'b1, 0);
        run_op("sub", 32'h12345678, 32'h12345679, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        run_op("sub_neg_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 0);
        run_op("sub_cin_ignored", 32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 0);
        run_op("backpressure", 32'h000000FF, 32'h00000001, 1'b1, 1'b0, 32'h00000101, 1'b0, 1'b0, 3);
        m = model(32'hDEADBEEF, 32'h21524111, 1'b0, 1'b0);
        run_op("model_add", 32'hDEADBEEF, 32'h21524111, 1'b0, 1'b0, m[31:0], m[32], m[33], 0);
        m = model(32'h7F00FF80, 32'h80FF0080, 1'b1, 1'b1);
        run_op("model_sub", 32'h7F00FF80, 32'h80FF0080, 1'b1, 1'b1, m[31:0], m[32], m[33], 0);

        bus.A = 32'hA5A5A5A5; bus.B = 32'h5A5A5A5B; bus.inValid = 1'b1;
        @(negedge clk);
        bus.inValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_inReady", 64'(bus.inReady), 64'd1);
        chk("abort_outValid", 64'(bus.outValid), 64'd0);
        chk("abort_S", 64'(bus.S), 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.outValid;
        end
        chk("abort_no_result", 64'(seen), 64'd0);

        run_op("post_abort", 32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
